vga_grid_timing_gen: RTL
========================

Name: vga_grid_timing_gen

Overview:
Parametrised VGA timing generator with a configurable cell-grid overlay and a per-frame cursor highlight. It sits between the frame-buffer/camera pixel source and the DE2-115 VGA DAC. Timing, grid geometry and colour width are all parameters. It adds frame-synchronous cursor sampling, a closing grid edge, cell-index outputs and a frame-start strobe.

Parameters:
H_SYNC_CYC, 128, hsync pulse width (pixels)
H_SYNC_BACK, 88, horizontal back porch
H_SYNC_ACT, 800, active pixels per line
H_SYNC_FRONT, 40, horizontal front porch
V_SYNC_CYC, 4, vsync pulse width (lines)
V_SYNC_BACK, 23, vertical back porch
V_SYNC_ACT, 600, active lines
V_SYNC_FRONT, 1, vertical front porch
COLOR_W, 10, bits per colour channel
GRID_COLS, 8, grid columns
GRID_ROWS, 8, grid rows
CELL_W, 70, cell pitch in x (pixels)
CELL_H, 72, cell pitch in y (lines)
GRID_X0, 120, grid left edge, active-area x
GRID_Y0, 10, grid top edge, active-area y
LINE_W, 5, grid line thickness (pixels/lines)
REQ_LEAD, 2, cycles oRequest leads active pixel

Ports:
iCLK  in  1  pixel clock
iRST_N  in  1  asynchronous active-low reset
iRed/iGreen/iBlue  in  COLOR_W each  pixel data for the requested pixel
iGrid_EN  in  1  1 = draw grid; 0 = pass-through inside active area
iCursor_X  in  4  cursor column
iCursor_Y  in  4  cursor row
iCursor_EN  in  1  cursor highlight enable
oRequest  out  1  pixel fetch request
oVGA_R/oVGA_G/oVGA_B  out  COLOR_W each  pixel to DAC
oVGA_H_SYNC, oVGA_V_SYNC  out  1  active-low syncs
oVGA_BLANK  out  1  H_SYNC & V_SYNC (registered)
oVGA_SYNC  out  1  constant 0
oH_Cont, oV_Cont  out  13  counter minus X_START / Y_START, 13-bit wrap
oCell_X, oCell_Y  out  4  grid cell of current pixel; GRID_COLS/GRID_ROWS when outside grid
oFrame_Start  out  1  one-cycle pulse per frame

Behaviour:
- X_START = H_SYNC_CYC + H_SYNC_BACK. Y_START = V_SYNC_CYC + V_SYNC_BACK. H_TOTAL and V_TOTAL are the sums of their four terms.
- Reset (async, iRST_N=0): the counters, all oVGA_*, oRequest, oFrame_Start, the cursor shadow and the cell counters clear to 0 immediately. This holds mid-frame. The first edge after release starts at H=0, V=0.
- H_Cont counts 0..H_TOTAL-1 and wraps to 0.
- V_Cont increments when H_Cont==H_TOTAL-1, counts 0..V_TOTAL-1 and wraps to 0.
- All oVGA_* and oFrame_Start are registered from the current counter state. Latency is one cycle.
- HSYNC=0 while H_Cont<H_SYNC_CYC, else 1. VSYNC=0 while V_Cont<V_SYNC_CYC, else 1.
- oFrame_Start=1 for one cycle after counters were at (0,0).
- Active region: x=H_Cont-X_START in [0,H_SYNC_ACT) and y=V_Cont-Y_START in [0,V_SYNC_ACT).
- Outside the active region, RGB=0.
- oRequest is registered. It is 1 when H_Cont is in [X_START-REQ_LEAD, X_START+H_SYNC_ACT-REQ_LEAD) and y is active.
- Cell tracking uses incremental counters (cell index, sub-offset), not division.
  - The x cell counter resets at x=GRID_X0. sub_x counts 0..CELL_W-1; cell_x increments on wrap and saturates at GRID_COLS.
  - The y counters behave the same with GRID_Y0, CELL_H and GRID_ROWS.
- Grid extent: x in [GRID_X0, GRID_X0+GRID_COLS*CELL_W+LINE_W), with y defined the same way.
  - Inside active but outside the grid extent, RGB=0 when iGrid_EN=1.
  - When iGrid_EN=0, RGB=input throughout the active region.
- Line pixel: inside the grid extent and (sub_x<LINE_W or sub_y<LINE_W). The closing edge at cell index GRID_COLS/GRID_ROWS is covered by sub<LINE_W.
  - Line pixel output: R = all ones; G and B = input.
  - Non-line pixel inside the grid: RGB = input.
- Cursor shadow: iCursor_X/Y/EN are registered only at H=0,V=0. Changes mid-frame take effect next frame.
  - If the shadow X>=GRID_COLS or Y>=GRID_ROWS, the cursor is disabled.
- Cursor border: line pixels that bound cell (cx,cy).
  - Vertical lines: cell_x in {cx,cx+1}, sub_x<LINE_W, cell_y==cy, or cell_y==cy+1 with sub_y<LINE_W.
  - Horizontal lines: the symmetric case in y.
  - Border output: R=0, G=all ones, B=0. This overrides the normal line colour.
- Arithmetic: all counters and comparisons are 13-bit unsigned. Parameter sums must fit 13 bits.

Test Plan:
1. Reset asserted for 10 cycles, then released → all outputs 0 during reset. HSYNC low for 128 cycles every 1056. VSYNC low for 4 lines every 628. Reasserting reset mid-line zeroes all outputs asynchronously.
2. Free run for 2 frames → oFrame_Start pulses exactly 663168 cycles apart. oH_Cont=0 at the first active pixel. oRequest rises 2 cycles before it.
3. iGrid_EN=1, cursor off, iRed=0x100, iGreen=0x0AA, iBlue=0x055:
   - x=120,y=20 → R=0x3FF, G=0x0AA, B=0x055
   - x=125,y=20 → R=0x100
   - x=119 → RGB=0
   - x=680..684 → line
   - x=685 → 0
4. Cursor (2,3), EN=1, set before frame → at x=260,y=236: R=0, G=0x3FF, B=0. Cell (0,0) lines stay red. Changing the cursor to (5,5) mid-frame leaves (2,3) highlighted until the next oFrame_Start.
5. Cursor (8,0), EN=1 → no green pixels anywhere in the frame.
6. iGrid_EN=0, input constant 0x2AA → every active pixel = 0x2AA. Blanking pixels = 0. oCell_X=8 outside the grid.

Source files
------------

// File: rtl/vga_grid_timing_gen_if.sv
// Pixel-side bundle for the VGA grid timing generator: pixel source and cursor in,
// DAC pixel, syncs, counters and cell indices out.
interface vga_grid_timing_gen_if #(
    parameter int COLOR_W = 10
);
    logic [COLOR_W-1:0] red;
    logic [COLOR_W-1:0] green;
    logic [COLOR_W-1:0] blue;
    logic               grid_en;
    logic [3:0]         cursor_x;
    logic [3:0]         cursor_y;
    logic               cursor_en;

    logic               request;
    logic [COLOR_W-1:0] vga_r;
    logic [COLOR_W-1:0] vga_g;
    logic [COLOR_W-1:0] vga_b;
    logic               vga_h_sync;
    logic               vga_v_sync;
    logic               vga_blank;
    logic               vga_sync;
    logic [12:0]        h_cont;
    logic [12:0]        v_cont;
    logic [3:0]         cell_x;
    logic [3:0]         cell_y;
    logic               frame_start;

    modport master (
        output red, green, blue, grid_en, cursor_x, cursor_y, cursor_en,
        input  request, vga_r, vga_g, vga_b, vga_h_sync, vga_v_sync, vga_blank,
               vga_sync, h_cont, v_cont, cell_x, cell_y, frame_start
    );

    modport slave (
        input  red, green, blue, grid_en, cursor_x, cursor_y, cursor_en,
        output request, vga_r, vga_g, vga_b, vga_h_sync, vga_v_sync, vga_blank,
               vga_sync, h_cont, v_cont, cell_x, cell_y, frame_start
    );
endinterface

// File: rtl/vga_grid_timing_gen.sv
// VGA timing generator with a cell-grid overlay and a frame-locked cursor highlight.
// Every output is registered from the current counter position (one cycle latency).
module vga_grid_timing_gen #(
    parameter int H_SYNC_CYC   = 128,
    parameter int H_SYNC_BACK  = 88,
    parameter int H_SYNC_ACT   = 800,
    parameter int H_SYNC_FRONT = 40,
    parameter int V_SYNC_CYC   = 4,
    parameter int V_SYNC_BACK  = 23,
    parameter int V_SYNC_ACT   = 600,
    parameter int V_SYNC_FRONT = 1,
    parameter int COLOR_W      = 10,
    parameter int GRID_COLS    = 8,
    parameter int GRID_ROWS    = 8,
    parameter int CELL_W       = 70,
    parameter int CELL_H       = 72,
    parameter int GRID_X0      = 120,
    parameter int GRID_Y0      = 10,
    parameter int LINE_W       = 5,
    parameter int REQ_LEAD     = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    vga_grid_timing_gen_if.slave  bus
);
    localparam int X_START_I = H_SYNC_CYC + H_SYNC_BACK;
    localparam int Y_START_I = V_SYNC_CYC + V_SYNC_BACK;
    localparam int H_TOTAL_I = H_SYNC_CYC + H_SYNC_BACK + H_SYNC_ACT + H_SYNC_FRONT;
    localparam int V_TOTAL_I = V_SYNC_CYC + V_SYNC_BACK + V_SYNC_ACT + V_SYNC_FRONT;

    localparam logic [12:0] X_START    = 13'(X_START_I);
    localparam logic [12:0] Y_START    = 13'(Y_START_I);
    localparam logic [12:0] H_LAST     = 13'(H_TOTAL_I - 1);
    localparam logic [12:0] V_LAST     = 13'(V_TOTAL_I - 1);
    localparam logic [12:0] H_ACT      = 13'(H_SYNC_ACT);
    localparam logic [12:0] V_ACT      = 13'(V_SYNC_ACT);
    localparam logic [12:0] HS_END     = 13'(H_SYNC_CYC);
    localparam logic [12:0] VS_END     = 13'(V_SYNC_CYC);
    localparam logic [12:0] REQ_LO     = 13'(X_START_I - REQ_LEAD);
    localparam logic [12:0] REQ_HI     = 13'(X_START_I + H_SYNC_ACT - REQ_LEAD);
    localparam logic [12:0] GX_LO      = 13'(GRID_X0);
    localparam logic [12:0] GX_HI      = 13'(GRID_X0 + GRID_COLS * CELL_W + LINE_W);
    localparam logic [12:0] GY_LO      = 13'(GRID_Y0);
    localparam logic [12:0] GY_HI      = 13'(GRID_Y0 + GRID_ROWS * CELL_H + LINE_W);
    localparam logic [12:0] SUB_X_LAST = 13'(CELL_W - 1);
    localparam logic [12:0] SUB_Y_LAST = 13'(CELL_H - 1);
    localparam logic [12:0] LINE       = 13'(LINE_W);
    localparam logic [3:0]  COLS       = 4'(GRID_COLS);
    localparam logic [3:0]  ROWS       = 4'(GRID_ROWS);

    logic [12:0] h_reg, h_next, v_reg, v_next;
    logic [12:0] x, y, x_next, y_next;
    logic        h_end;

    logic [12:0] sub_x_reg, sub_x_next, sub_y_reg, sub_y_next;
    logic [3:0]  cell_x_reg, cell_x_next, cell_y_reg, cell_y_next;

    logic [3:0]  cur_x_reg, cur_y_reg;
    logic        cur_en_reg;

    logic        frame_origin, active, in_grid, line_x, line_y, grid_line;
    logic        cursor_on, col_own, col_adj, row_own, row_adj, border, request_next;
    logic [4:0]  cell_x_w, cell_y_w, cur_x_w, cur_y_w;

    logic        hs_reg, vs_reg, blank_reg, request_reg, frame_start_reg;
    logic [12:0] h_cont_reg, v_cont_reg;
    logic [3:0]  cell_out_x_reg, cell_out_y_reg;

    always_comb begin
        h_end  = (h_reg == H_LAST);
        h_next = h_end ? 13'd0 : h_reg + 13'd1;
        v_next = v_reg;
        if (h_end) begin
            v_next = (v_reg == V_LAST) ? 13'd0 : v_reg + 13'd1;
        end
        x      = h_reg - X_START;
        y      = v_reg - Y_START;
        x_next = h_next - X_START;
        y_next = v_next - Y_START;
    end

    // Cell/sub-offset counters are re-anchored at the grid origin each line/frame and
    // otherwise free-run; the cell index saturates so the closing edge reads as GRID_COLS/ROWS.
    always_comb begin
        sub_x_next  = sub_x_reg + 13'd1;
        cell_x_next = cell_x_reg;
        if (x_next == GX_LO) begin
            sub_x_next  = 13'd0;
            cell_x_next = 4'd0;
        end else if (sub_x_reg == SUB_X_LAST) begin
            sub_x_next = 13'd0;
            if (cell_x_reg != COLS) cell_x_next = cell_x_reg + 4'd1;
        end

        sub_y_next  = sub_y_reg;
        cell_y_next = cell_y_reg;
        if (h_end) begin
            if (y_next == GY_LO) begin
                sub_y_next  = 13'd0;
                cell_y_next = 4'd0;
            end else if (sub_y_reg == SUB_Y_LAST) begin
                sub_y_next = 13'd0;
                if (cell_y_reg != ROWS) cell_y_next = cell_y_reg + 4'd1;
            end else begin
                sub_y_next = sub_y_reg + 13'd1;
            end
        end
    end

    always_comb begin
        frame_origin = (h_reg == 13'd0) && (v_reg == 13'd0);
        active       = (x < H_ACT) && (y < V_ACT);
        in_grid      = active && (x >= GX_LO) && (x < GX_HI) && (y >= GY_LO) && (y < GY_HI);
        line_x       = (sub_x_reg < LINE);
        line_y       = (sub_y_reg < LINE);
        grid_line    = line_x || line_y;
        request_next = (h_reg >= REQ_LO) && (h_reg < REQ_HI) && (y < V_ACT);

        cell_x_w  = {1'b0, cell_x_reg};
        cell_y_w  = {1'b0, cell_y_reg};
        cur_x_w   = {1'b0, cur_x_reg};
        cur_y_w   = {1'b0, cur_y_reg};
        cursor_on = cur_en_reg && (cur_x_reg < COLS) && (cur_y_reg < ROWS);
        col_own   = (cell_x_w == cur_x_w);
        col_adj   = (cell_x_w == cur_x_w + 5'd1);
        row_own   = (cell_y_w == cur_y_w);
        row_adj   = (cell_y_w == cur_y_w + 5'd1);
        // Border = the four line segments that enclose the cursor cell, including the corners.
        border    = cursor_on &&
                    (((col_own || col_adj) && line_x && (row_own || (row_adj && line_y))) ||
                     ((row_own || row_adj) && line_y && (col_own || (col_adj && line_x))));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_reg           <= '0;
            v_reg           <= '0;
            sub_x_reg       <= '0;
            sub_y_reg       <= '0;
            cell_x_reg      <= '0;
            cell_y_reg      <= '0;
            cur_x_reg       <= '0;
            cur_y_reg       <= '0;
            cur_en_reg      <= 1'b0;
            hs_reg          <= 1'b0;
            vs_reg          <= 1'b0;
            blank_reg       <= 1'b0;
            request_reg     <= 1'b0;
            frame_start_reg <= 1'b0;
            h_cont_reg      <= '0;
            v_cont_reg      <= '0;
            cell_out_x_reg  <= '0;
            cell_out_y_reg  <= '0;
        end else begin
            h_reg      <= h_next;
            v_reg      <= v_next;
            sub_x_reg  <= sub_x_next;
            sub_y_reg  <= sub_y_next;
            cell_x_reg <= cell_x_next;
            cell_y_reg <= cell_y_next;
            if (frame_origin) begin
                cur_x_reg  <= bus.cursor_x;
                cur_y_reg  <= bus.cursor_y;
                cur_en_reg <= bus.cursor_en;
            end
            hs_reg          <= (h_reg >= HS_END);
            vs_reg          <= (v_reg >= VS_END);
            blank_reg       <= (h_reg >= HS_END) && (v_reg >= VS_END);
            request_reg     <= request_next;
            frame_start_reg <= frame_origin;
            h_cont_reg      <= x;
            v_cont_reg      <= y;
            cell_out_x_reg  <= in_grid ? cell_x_reg : COLS;
            cell_out_y_reg  <= in_grid ? cell_y_reg : ROWS;
        end
    end

    // Channel 0 = red, 1 = green, 2 = blue; only the colour constants differ per channel.
    for (genvar gi = 0; gi < 3; gi++) begin : g_chan
        logic [COLOR_W-1:0] chan_in;
        logic [COLOR_W-1:0] chan_next;
        logic [COLOR_W-1:0] chan_reg;

        if (gi == 0) begin : g_red
            assign chan_in   = bus.red;
            assign bus.vga_r = chan_reg;
        end else if (gi == 1) begin : g_green
            assign chan_in   = bus.green;
            assign bus.vga_g = chan_reg;
        end else begin : g_blue
            assign chan_in   = bus.blue;
            assign bus.vga_b = chan_reg;
        end

        always_comb begin
            chan_next = '0;
            if (active) begin
                if (!bus.grid_en) begin
                    chan_next = chan_in;
                end else if (in_grid) begin
                    if (border) begin
                        chan_next = (gi == 1) ? {COLOR_W{1'b1}} : {COLOR_W{1'b0}};
                    end else if (grid_line) begin
                        chan_next = (gi == 0) ? {COLOR_W{1'b1}} : chan_in;
                    end else begin
                        chan_next = chan_in;
                    end
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) chan_reg <= '0;
            else        chan_reg <= chan_next;
        end
    end

    assign bus.request     = request_reg;
    assign bus.vga_h_sync  = hs_reg;
    assign bus.vga_v_sync  = vs_reg;
    assign bus.vga_blank   = blank_reg;
    assign bus.vga_sync    = 1'b0;
    assign bus.h_cont      = h_cont_reg;
    assign bus.v_cont      = v_cont_reg;
    assign bus.cell_x      = cell_out_x_reg;
    assign bus.cell_y      = cell_out_y_reg;
    assign bus.frame_start = frame_start_reg;
endmodule
